// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential PC generation, 1-cycle imem issue,
// small return FIFO toward decode, and redirect flush of queued/in-flight words.
module ifetch_queue #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            imem_req,
  output logic [ADDR_W-1:0]               imem_addr,
  input  logic [INSTR_W-1:0]              imem_rdata,
  input  logic                            redirect_valid,
  input  logic [ADDR_W-1:0]               redirect_pc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [INSTR_W-1:0]              out_instr,
  output logic [ADDR_W-1:0]               out_pc,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  fetch_pc;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];

  logic [CNT_W-1:0]   credit_used;
  logic               issue;
  logic               push;
  logic               pop;

  // Credit: queued entries plus the outstanding request must leave a free slot.
  always_comb begin
    credit_used = count + CNT_W'(inflight);
    issue       = !rst && !redirect_valid && (credit_used < CNT_W'(DEPTH));
    push        = !rst && !redirect_valid && inflight;
    pop         = !rst && !redirect_valid && out_valid && out_ready;
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign out_valid = !rst && (count != '0);
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  // Fetch PC, in-flight tracking, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + ADDR_W'(1);
        inflight_pc <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage for returned words tagged with their fetch address.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end

  // A push into a full FIFO means the credit check is broken.
  always_ff @(posedge clk) begin
    if (push && !pop) begin
      assert (count != CNT_W'(DEPTH))
        else $error("ifetch_queue: push into full FIFO");
    end
  end

endmodule
